sprite_blitter: RTL and testbench



---
 rtl/blit_pkg.sv | 20 ++
 rtl/blit_addr_gen.sv | 56 +++++
 rtl/sprite_blitter.sv | 133 +++++++++++++
 tb/tb_sprite_blitter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/blit_pkg.sv
// Shared types and default geometry for the sprite blitter.
// Optional horizontal mirroring is enabled with BLITTER_FLIP_X_EN.
package blit_pkg;

   localparam int SPR_W_DEF      = 50;
   localparam int SPR_H_DEF      = 64;
   localparam int IDX_W_DEF      = 3;
   localparam int ROM_AW_DEF     = 12;
   localparam int FB_W_DEF       = 640;
   localparam int FB_H_DEF       = 480;
   localparam int FB_AW_DEF      = 19;
   localparam int TRANSP_IDX_DEF = 0;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

endpackage

// File: rtl/blit_addr_gen.sv
// Raster col/row walker and sprite ROM address generator.
// BLITTER_FLIP_X_EN adds a flip input that mirrors the ROM column.
module blit_addr_gen
   import blit_pkg::*;
#(
   parameter int SPR_W  = SPR_W_DEF,
   parameter int SPR_H  = SPR_H_DEF,
   parameter int ROM_AW = ROM_AW_DEF,
   parameter int CW     = $clog2(SPR_W),
   parameter int RW     = $clog2(SPR_H)
) (
   input  logic              vga_clk,
   input  logic              Reset,
   input  logic              clear,
   input  logic              advance,
`ifdef BLITTER_FLIP_X_EN
   input  logic              flip,
`endif
   output logic [CW-1:0]     col,
   output logic [RW-1:0]     row,
   output logic              last,
   output logic [ROM_AW-1:0] rom_address
);

   logic          col_end;
   logic          row_end;
   logic [CW-1:0] rom_col;

   assign col_end = (col == CW'(SPR_W - 1));
   assign row_end = (row == RW'(SPR_H - 1));
   assign last    = col_end && row_end;

   always_ff @(posedge vga_clk) begin
      if (Reset || clear) begin
         col <= '0;
         row <= '0;
      end else if (advance) begin
         if (col_end) begin
            col <= '0;
            row <= row_end ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

`ifdef BLITTER_FLIP_X_EN
   assign rom_col = flip ? (CW'(SPR_W - 1) - col) : col;
`else
   assign rom_col = col;
`endif

   assign rom_address = ROM_AW'(row) * ROM_AW'(SPR_W)
                      + ROM_AW'(rom_col);

endmodule

// File: rtl/sprite_blitter.sv
// Walks a sprite ROM once and writes opaque, on-screen pixels to the frame buffer.
// Define BLITTER_FLIP_X_EN for the flip_x port (horizontal mirroring).
module sprite_blitter
   import blit_pkg::*;
#(
   parameter int SPR_W      = SPR_W_DEF,
   parameter int SPR_H      = SPR_H_DEF,
   parameter int IDX_W      = IDX_W_DEF,
   parameter int ROM_AW     = ROM_AW_DEF,
   parameter int FB_W       = FB_W_DEF,
   parameter int FB_H       = FB_H_DEF,
   parameter int FB_AW      = FB_AW_DEF,
   parameter int TRANSP_IDX = TRANSP_IDX_DEF
) (
   input  logic              vga_clk,
   input  logic              Reset,
   input  logic              start,
   input  logic [9:0]        pos_x,
   input  logic [9:0]        pos_y,
`ifdef BLITTER_FLIP_X_EN
   input  logic              flip_x,
`endif
   output logic              busy,
   output logic              done,
   output logic [ROM_AW-1:0] rom_address,
   input  logic [IDX_W-1:0]  rom_q,
   output logic              fb_we,
   output logic [FB_AW-1:0]  fb_addr,
   output logic [IDX_W-1:0]  fb_data
);

   localparam int CW = $clog2(SPR_W);
   localparam int RW = $clog2(SPR_H);

   state_t        state;
   state_t        state_nxt;
   logic          accept;
   logic          running;
   logic          last;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [9:0]    px_q;
   logic [9:0]    py_q;
   logic          valid_d;
   logic [CW-1:0] col_d;
   logic [RW-1:0] row_d;
   logic [10:0]   scr_x;
   logic [10:0]   scr_y;
   logic          on_screen;
   logic          opaque;
`ifdef BLITTER_FLIP_X_EN
   logic          flip_q;
`endif

   assign accept  = (state == IDLE) && start;
   assign running = (state == RUN);
   assign busy    = (state != IDLE);

   blit_addr_gen #(
      .SPR_W  (SPR_W),
      .SPR_H  (SPR_H),
      .ROM_AW (ROM_AW),
      .CW     (CW),
      .RW     (RW)
   ) u_addr (
      .vga_clk     (vga_clk),
      .Reset       (Reset),
      .clear       (accept),
      .advance     (running),
`ifdef BLITTER_FLIP_X_EN
      .flip        (flip_q),
`endif
      .col         (col),
      .row         (row),
      .last        (last),
      .rom_address (rom_address)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DRAIN;
         DRAIN:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // col/row/valid ride one stage behind the address to meet rom_q
   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         state   <= IDLE;
         done    <= 1'b0;
         valid_d <= 1'b0;
         col_d   <= '0;
         row_d   <= '0;
         px_q    <= '0;
         py_q    <= '0;
      end else begin
         state   <= state_nxt;
         done    <= (state == DRAIN);
         valid_d <= running;
         col_d   <= col;
         row_d   <= row;
         if (accept) begin
            px_q <= pos_x;
            py_q <= pos_y;
         end
      end
   end

`ifdef BLITTER_FLIP_X_EN
   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         flip_q <= 1'b0;
      end else if (accept) begin
         flip_q <= flip_x;
      end
   end
`endif

   // 11-bit sums so a sprite hanging off the right/bottom never wraps
   assign scr_x     = 11'(px_q) + 11'(col_d);
   assign scr_y     = 11'(py_q) + 11'(row_d);
   assign on_screen = (scr_x < 11'(FB_W)) && (scr_y < 11'(FB_H));
   assign opaque    = (rom_q != IDX_W'(TRANSP_IDX));

   assign fb_we   = valid_d && opaque && on_screen;
   assign fb_addr = fb_we ? (FB_AW'(scr_y) * FB_AW'(FB_W) + FB_AW'(scr_x))
                          : '0;
   assign fb_data = fb_we ? rom_q : '0;

endmodule

// File: tb/tb_sprite_blitter.sv
// Randomized self-checking bench for sprite_blitter against a raster model.
// Exercises flip_x as well when BLITTER_FLIP_X_EN is defined.
module tb_sprite_blitter;

   localparam int SW  = 50;
   localparam int SH  = 64;
   localparam int N   = SW * SH;
   localparam int LEN = N + 6;

   logic        vga_clk = 1'b0;
   logic        Reset   = 1'b1;
   logic        start   = 1'b0;
   logic [9:0]  pos_x   = '0;
   logic [9:0]  pos_y   = '0;
   logic        flip_x  = 1'b0;
   logic        busy;
   logic        done;
   logic [11:0] rom_address;
   logic [2:0]  rom_q = '0;
   logic        fb_we;
   logic [18:0] fb_addr;
   logic [2:0]  fb_data;

   logic [2:0]  rom_mem [0:4095];

   int n_cmp = 0;
   int n_bad = 0;

   bit exp_we   [0:LEN-1];
   int exp_addr [0:LEN-1];
   int exp_data [0:LEN-1];

   int n_we, first_cyc, first_addr, last_cyc, last_addr;
   int done_cyc, n_done, rom_at1, rom_at100;
   int bad_we, bad_wd, bad_busy, bad_rom, exp_n;

   always #5 vga_clk = ~vga_clk;

   always @(posedge vga_clk) rom_q <= rom_mem[rom_address];

   sprite_blitter dut (
      .vga_clk     (vga_clk),
      .Reset       (Reset),
      .start       (start),
      .pos_x       (pos_x),
      .pos_y       (pos_y),
`ifdef BLITTER_FLIP_X_EN
      .flip_x      (flip_x),
`endif
      .busy        (busy),
      .done        (done),
      .rom_address (rom_address),
      .rom_q       (rom_q),
      .fb_we       (fb_we),
      .fb_addr     (fb_addr),
      .fb_data     (fb_data)
   );

   task automatic check(input string tag, input longint obs,
                        input longint exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic fill_rom(input int mode);
      for (int a = 0; a < 4096; a++) begin
         int r = a / SW;
         int c = a % SW;
         case (mode)
            0:       rom_mem[a] = 3'd5;
            1:       rom_mem[a] = ((r + c) % 2 == 1) ? 3'd3 : 3'd0;
            default: rom_mem[a] = 3'($urandom_range(0, 7));
         endcase
      end
   endtask

   function automatic int rom_col(input int c, input bit fl);
`ifdef BLITTER_FLIP_X_EN
      return fl ? (SW - 1 - c) : c;
`else
      return c;
`endif
   endfunction

   // rst_at: cycle whose closing edge sees Reset (0 = none)
   // rs_at : cycle in which a second, ignored start is pulsed (0 = none)
   // pre   : start was already issued by a chained predecessor
   // chain : issue the next start in the same cycle as done
   task automatic run_blit(input int px, input int py, input bit fl,
                           input int rst_at, input int rs_at,
                           input bit pre, input bit chain);
      exp_n = 0;
      for (int c = 0; c < LEN; c++) begin
         exp_we[c] = 0; exp_addr[c] = 0; exp_data[c] = 0;
      end
      for (int k = 0; k < N; k++) begin
         int c   = k + 2;
         int r   = k / SW;
         int cc  = k % SW;
         int idx = int'(rom_mem[r * SW + rom_col(cc, fl)]);
         int x   = px + cc;
         int y   = py + r;
         if (rst_at > 0 && c > rst_at) continue;
         if (idx != 0 && x < 640 && y < 480) begin
            exp_we[c] = 1; exp_addr[c] = y * 640 + x;
            exp_data[c] = idx; exp_n++;
         end
      end
      n_we = 0; first_cyc = -1; first_addr = -1;
      last_cyc = -1; last_addr = -1; done_cyc = -1; n_done = 0;
      bad_we = 0; bad_wd = 0; bad_busy = 0; bad_rom = 0;
      rom_at1 = -1; rom_at100 = -1;

      if (!pre) begin
         @(negedge vga_clk);
         start = 1; pos_x = 10'(px); pos_y = 10'(py); flip_x = fl;
         @(posedge vga_clk);
         @(negedge vga_clk);
      end
      start = 0; pos_x = 10'($urandom); pos_y = 10'($urandom);
      flip_x = 1'($urandom);

      for (int c = 1; c < LEN; c++) begin
         bit alive = !(rst_at > 0 && c > rst_at);
         bit eb    = alive && c <= N + 1;
         if (busy !== eb) bad_busy++;
         if (done === 1'b1) begin n_done++; done_cyc = c; end
         else if (done !== 1'b0) bad_busy++;
         if (fb_we !== exp_we[c]) bad_we++;
         else if (fb_we && (int'(fb_addr) != exp_addr[c] ||
                            int'(fb_data) != exp_data[c])) bad_wd++;
         if (fb_we === 1'b1) begin
            n_we++;
            if (first_cyc < 0) begin
               first_cyc = c; first_addr = int'(fb_addr);
            end
            last_cyc = c; last_addr = int'(fb_addr);
         end
         if (alive && c <= N) begin
            int k = c - 1;
            int ea = (k / SW) * SW + rom_col(k % SW, fl);
            if (int'(rom_address) != ea) bad_rom++;
         end
         if (c == 1)   rom_at1   = int'(rom_address);
         if (c == 100) rom_at100 = int'(rom_address);

         Reset = (c == rst_at);
         if (c == rs_at) begin
            start = 1; pos_x = 10'(px + 211); pos_y = 10'(py + 97);
         end else if (chain && c == N + 2) begin
            start = 1; pos_x = 10'(px); pos_y = 10'(py); flip_x = fl;
            @(posedge vga_clk);
            @(negedge vga_clk);
            break;
         end else begin
            start = 0;
         end
         @(posedge vga_clk);
         @(negedge vga_clk);
      end
      Reset = 0;

      check("n_writes", n_we, exp_n);
      check("we_timing", bad_we, 0);
      check("wr_addr_data", bad_wd, 0);
      check("busy_done_level", bad_busy, 0);
      check("rom_addr_seq", bad_rom, 0);
      check("done_count", n_done, (rst_at > 0) ? 0 : 1);
      if (rst_at == 0) check("done_cycle", done_cyc, N + 2);
   endtask

   initial begin
      fill_rom(0);
      repeat (3) @(posedge vga_clk);
      @(negedge vga_clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_fb_we", fb_we, 0);
      check("rst_fb_addr", fb_addr, 0);
      check("rst_fb_data", fb_data, 0);
      check("rst_rom_addr", rom_address, 0);
      Reset = 0;
      @(negedge vga_clk);
      check("idle_busy", busy, 0);

      run_blit(100, 50, 0, 0, 0, 0, 0);
      check("first_addr", first_addr, 32100);
      check("first_cycle", first_cyc, 2);
      check("last_addr", last_addr, 72469);
      check("last_cycle", last_cyc, 3201);

      fill_rom(1);
      run_blit(10, 20, 0, 0, 0, 0, 0);
      check("checker_writes", n_we, 1600);

      fill_rom(0);
      run_blit(620, 450, 0, 0, 0, 0, 0);
      check("clip_writes", n_we, 600);

      run_blit(300, 200, 0, 0, 1000, 0, 0);

      run_blit(40, 40, 0, 500, 0, 0, 0);
      check("reset_writes_cut", n_we, 499);
      run_blit(0, 0, 0, 0, 0, 0, 0);
      check("post_reset_writes", n_we, 3200);

      fill_rom(2);
      run_blit(5, 7, 0, 0, 0, 0, 1);
      run_blit(5, 7, 0, 0, 0, 1, 0);

      for (int i = 0; i < 3; i++) begin
         fill_rom(2);
         run_blit(int'($urandom_range(0, 1023)),
                  int'($urandom_range(0, 1023)),
                  1'($urandom), 0, 0, 0, 0);
      end

`ifdef BLITTER_FLIP_X_EN
      fill_rom(2);
      run_blit(200, 100, 1, 0, 0, 0, 0);
      check("flip_rom_c0r0", rom_at1, 49);
      check("flip_rom_c49r1", rom_at100, 50);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
